viterbi_frame_decoder: RTL and testbench
========================================

// Module: viterbi_frame_decoder
// PURPOSE
//  Streaming hard-decision Viterbi decoder for rate-1/R, constraint-length-K convolutional codes.
//  Takes one R-bit code symbol per cycle (valid/ready), runs ACS over FRAME_LEN symbols, traces back once, emits decoded bits serially.
//  Generalises the fixed-length decoder: generator polynomials, frame length, termination mode, metric width, flow control.
// PARAMETERS
//  R          2         code bits per information bit
//  K          3         constraint length; NS=2**(K-1) states
//  G          6'b101111 packed polynomials, G[j*K +: K] = poly j (default g0=111, g1=101)
//  FRAME_LEN  6         symbols per frame (tail included if TERMINATED)
//  TERMINATED 1         1: frame ends with K-1 zero tail bits, traceback from state 0; 0: traceback from best state
//  METRIC_W   6         path-metric width; must hold R*FRAME_LEN+1, adds saturate at all-ones
// PORTS
//  clk         in   1         clock, rising edge
//  rst         in   1         synchronous reset, active-high
//  in_valid    in   1         in_sym valid
//  in_ready    out  1         decoder accepts a symbol
//  in_sym      in   R         code symbol; in_sym[j] = encoder output of poly j
//  out_valid   out  1         out_bit valid
//  out_ready   in   1         sink accepts out_bit
//  out_bit     out  1         decoded bit, time order (oldest first)
//  out_last    out  1         final decoded bit of the frame
//  out_metric  out  METRIC_W  path metric of traceback start state; stable while out_valid
//  frame_done  out  1         1-cycle pulse after last bit accepted
// BEHAVIOUR
//  Trellis: state s[K-2:0], s[K-2] newest bit. Input u: reg={u,s}; code bit j = ^(G[j*K+:K] & reg); next={u,s[K-2:1]}.
//  Predecessors of n: p_b={n[K-3:0],b}, b in {0,1} (K=2: p_b=b). u = n[K-2].
//  Branch metric: Hamming distance in_sym vs expected code, 0..R.
//  FSM: ACS -> TRACE -> OUT -> ACS.
//  ACS: in_ready=1. Per accepted symbol (in_valid&in_ready), all NS states update in that cycle:
//   pm'[n]=min(pm[p0]+bm0, pm[p1]+bm1) (saturating); tie picks b=0; survivor bit b stored at [t][n].
//   Frame start: pm[0]=0, pm[others]=R*FRAME_LEN+1; t=0. After symbol FRAME_LEN-1 accepted -> TRACE next cycle.
//  TRACE: in_ready=0. Start state 0 (TERMINATED) or lowest-index argmin pm. out_metric latched = pm[start].
//   One step/cycle, t=FRAME_LEN-1..0: bit[t]=st[K-2]; st={st[K-3:0],surv[t][st]}. Exactly FRAME_LEN cycles, then OUT.
//  OUT: NOUT = FRAME_LEN-(K-1) if TERMINATED else FRAME_LEN. out_valid=1 with out_bit=bit[i], i from 0.
//   out_valid rises FRAME_LEN+1 edges after the edge accepting the last symbol. Advance i only on out_valid&out_ready;
//   out_bit/out_last hold under backpressure. out_last=1 when i=NOUT-1. Last accept -> frame_done=1 one cycle,
//   out_valid=0, pm re-init, back to ACS (in_ready=1 that cycle). No overlap of frames.
//  Reset values: in_ready=1 (state ACS after reset), out_valid=0, out_bit=0, out_last=0, out_metric=0, frame_done=0,
//   pm as at frame start, t=0.
//  rst in any state aborts frame, discards survivors/output, returns to ACS next cycle. in_valid outside ACS ignored.
//  Survivor store: FRAME_LEN x NS bit registers; decoded buffer FRAME_LEN bits.
// TESTING
//  1 Defaults, symbols {g1,g0}: 11,01,00,10,10,11 (bits 1011+00 tail), out_ready=1 -> out 1,0,1,1; out_last on 4th;
//    out_metric=0; frame_done one cycle after; out_valid first at edge 7 after last symbol.
//  2 Same, first symbol 10 (one bit error) -> out 1,0,1,1, out_metric=1.
//  3 TERMINATED=0, FRAME_LEN=4, symbols 11,01,00,10 -> out 1,0,1,1 (start state 2'b11), out_metric=0.
//  4 in_valid toggled 1/0 every cycle, out_ready low 3 cycles per bit -> same bits, out_bit stable while stalled, in_ready=0 in TRACE/OUT.
//  5 rst pulsed after 3rd symbol of scenario 1 -> out_valid stays 0; then full scenario 1 -> out 1011 correct.
//  6 Two back-to-back frames (1011, then 0110 encoded+tail) -> outputs 1011 then 0110, two frame_done pulses, metric 0 each.

Source files
------------

// File: rtl/viterbi_frame_decoder.sv
// Frame-based hard-decision Viterbi decoder: per-symbol ACS over all states,
// one traceback per frame, then serial bit output under valid/ready.
module viterbi_frame_decoder #(
  parameter int R = 2,
  parameter int K = 3,
  parameter logic [R*K-1:0] G = 6'b101111,
  parameter int FRAME_LEN = 6,
  parameter int TERMINATED = 1,
  parameter int METRIC_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [R-1:0]        in_sym,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_bit,
  output logic                out_last,
  output logic [METRIC_W-1:0] out_metric,
  output logic                frame_done
);

  localparam int NS = 2 ** (K - 1);
  localparam int SW = K - 1;
  localparam int TW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int NOUT = (TERMINATED != 0) ? FRAME_LEN - (K - 1) : FRAME_LEN;
  localparam logic [TW-1:0] T_LAST = TW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] I_LAST = TW'(NOUT - 1);
  localparam logic [METRIC_W-1:0] PM_INIT = METRIC_W'(R * FRAME_LEN + 1);

  typedef enum logic [1:0] {
    S_ACS,
    S_TRACE,
    S_OUT
  } state_t;

  state_t state;
  logic [METRIC_W-1:0] pm [NS];
  logic [METRIC_W-1:0] pm_n [NS];
  logic [METRIC_W-1:0] c0 [NS];
  logic [METRIC_W-1:0] c1 [NS];
  logic [NS-1:0] sv_n;
  logic [NS-1:0] surv [FRAME_LEN];
  logic [FRAME_LEN-1:0] dec;
  logic [TW-1:0] t;
  logic [TW-1:0] idx;
  logic [TW-1:0] idx_nx;
  logic [SW-1:0] st;
  logic [SW-1:0] st_cur;
  logic [SW-1:0] st_next;
  logic [SW-1:0] best;
  logic [SW-1:0] start;
  logic accept;

  function automatic logic [SW-1:0] pred(input int n, input logic b);
    return SW'(2 * n + int'(b));
  endfunction

  function automatic logic [METRIC_W-1:0] branch_metric(
    input int n,
    input logic b,
    input logic [R-1:0] sym
  );
    logic [SW-1:0] nn;
    logic [K-1:0] r;
    logic [METRIC_W-1:0] d;
    nn = SW'(n);
    r = {nn[SW-1], pred(n, b)};
    d = '0;
    for (int j = 0; j < R; j++)
      d = d + METRIC_W'(sym[j] ^ (^(G[j*K +: K] & r)));
    return d;
  endfunction

  function automatic logic [METRIC_W-1:0] sat_add(
    input logic [METRIC_W-1:0] a,
    input logic [METRIC_W-1:0] b
  );
    logic [METRIC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[METRIC_W] ? '1 : s[METRIC_W-1:0];
  endfunction

  assign accept = in_valid & in_ready;

  // Ties resolve towards the b=0 predecessor.
  always_comb begin
    sv_n = '0;
    for (int n = 0; n < NS; n++) begin
      c0[n] = sat_add(pm[pred(n, 1'b0)], branch_metric(n, 1'b0, in_sym));
      c1[n] = sat_add(pm[pred(n, 1'b1)], branch_metric(n, 1'b1, in_sym));
      pm_n[n] = c0[n];
      if (c1[n] < c0[n]) begin
        pm_n[n] = c1[n];
        sv_n[n] = 1'b1;
      end
    end
  end

  always_comb begin
    best = '0;
    for (int n = 1; n < NS; n++)
      if (pm[n] < pm[best]) best = SW'(n);
  end

  assign start = (TERMINATED != 0) ? '0 : best;
  assign st_cur = (t == T_LAST) ? start : st;
  assign st_next = SW'({st_cur, surv[t][st_cur]});
  assign idx_nx = idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_ACS;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_bit <= 1'b0;
      out_last <= 1'b0;
      out_metric <= '0;
      frame_done <= 1'b0;
      t <= '0;
      idx <= '0;
      st <= '0;
      for (int n = 0; n < NS; n++)
        pm[n] <= (n == 0) ? '0 : PM_INIT;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        S_ACS: begin
          if (accept) begin
            for (int n = 0; n < NS; n++) pm[n] <= pm_n[n];
            if (t == T_LAST) begin
              state <= S_TRACE;
              in_ready <= 1'b0;
            end else begin
              t <= t + 1'b1;
            end
          end
        end
        S_TRACE: begin
          if (t == T_LAST) out_metric <= pm[start];
          st <= st_next;
          if (t == '0) state <= S_OUT;
          else t <= t - 1'b1;
        end
        S_OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_bit <= dec[0];
            out_last <= (I_LAST == '0);
            idx <= '0;
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last <= 1'b0;
              frame_done <= 1'b1;
              state <= S_ACS;
              in_ready <= 1'b1;
              t <= '0;
              for (int n = 0; n < NS; n++)
                pm[n] <= (n == 0) ? '0 : PM_INIT;
            end else begin
              idx <= idx_nx;
              out_bit <= dec[idx_nx];
              out_last <= (idx_nx == I_LAST);
            end
          end
        end
        default: state <= S_ACS;
      endcase
    end
  end

  // Survivor and decoded-bit storage needs no reset: every frame rewrites it.
  always_ff @(posedge clk) begin
    if (state == S_ACS && accept) surv[t] <= sv_n;
    if (state == S_TRACE) dec[t] <= st_cur[SW-1];
  end

endmodule

// File: tb/tb_viterbi_frame_decoder.sv
// Randomized frame bench for viterbi_frame_decoder; expectations come from a
// direct encoder and brute-force maximum-likelihood search over all frames.
module tb_viterbi_frame_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic out_bit, out_last, frame_done;
  logic [1:0] in_sym;
  logic [5:0] out_metric;

  logic nt_in_valid, nt_in_ready, nt_out_valid, nt_out_ready;
  logic nt_out_bit, nt_out_last, nt_frame_done;
  logic [1:0] nt_in_sym;
  logic [5:0] nt_out_metric;

  int checks = 0;
  int failures = 0;

  viterbi_frame_decoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_last(out_last),
    .out_metric(out_metric), .frame_done(frame_done)
  );

  viterbi_frame_decoder #(.FRAME_LEN(4), .TERMINATED(0)) nt (
    .clk(clk), .rst(rst),
    .in_valid(nt_in_valid), .in_ready(nt_in_ready), .in_sym(nt_in_sym),
    .out_valid(nt_out_valid), .out_ready(nt_out_ready),
    .out_bit(nt_out_bit), .out_last(nt_out_last),
    .out_metric(nt_out_metric), .frame_done(nt_frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // info[i] is the bit at time i; symbol i sits at [2i+:2] as {g1,g0}.
  function automatic logic [11:0] encode(input logic [3:0] info);
    logic b1, b2, u;
    logic [11:0] e;
    b1 = 1'b0;
    b2 = 1'b0;
    e = '0;
    for (int i = 0; i < 6; i++) begin
      u = (i < 4) ? info[i] : 1'b0;
      e[2*i +: 2] = {u ^ b2, u ^ b1 ^ b2};
      b2 = b1;
      b1 = u;
    end
    return e;
  endfunction

  function automatic int ml_metric(input logic [11:0] rx);
    int m;
    m = 99;
    for (int c = 0; c < 16; c++)
      if ($countones(encode(4'(c)) ^ rx) < m)
        m = $countones(encode(4'(c)) ^ rx);
    return m;
  endfunction

  task automatic send(input logic [11:0] syms, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_sym = 2'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_sym = syms[2*i +: 2];
      check("in_ready_acs", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input logic [3:0] exp_bits, input bit exact,
                         input int exp_m, input bit stall, input bit noise,
                         output logic [3:0] got);
    int n;
    n = 0;
    got = '0;
    in_valid = noise;
    in_sym = 2'($urandom);
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
      in_sym = 2'($urandom);
      if (!out_valid) check("in_ready_busy", in_ready, 0);
    end
    check("latency", n, 7);
    if (!out_valid) return;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) in_valid = 1'b0;
      if (stall && exact) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check("stall_valid", out_valid, 1);
          check("stall_bit", out_bit, exp_bits[i]);
          check("stall_last", out_last, i == 3);
        end
      end
      check("in_ready_out", in_ready, 0);
      check("last", out_last, i == 3);
      check("metric", out_metric, exp_m);
      got[i] = out_bit;
      if (exact) check("bit", out_bit, exp_bits[i]);
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_sym = 2'($urandom);
    end
    check("frame_done", frame_done, 1);
    check("valid_low", out_valid, 0);
    check("in_ready_back", in_ready, 1);
    @(posedge clk); #1;
    check("done_pulse", frame_done, 0);
  endtask

  task automatic run_frame(input logic [3:0] info, input logic [11:0] err,
                           input bit stall, input bit gaps, input bit noise);
    logic [11:0] rx;
    logic [3:0] got;
    bit exact;
    int exp_m;
    rx = encode(info) ^ err;
    exact = ($countones(err) <= 2);
    exp_m = ml_metric(rx);
    send(rx, 6, gaps);
    collect(info, exact, exp_m, stall, noise, got);
    if (!exact) check("ml_path", $countones(encode(got) ^ rx), exp_m);
  endtask

  initial begin
    logic [3:0] info;
    logic [11:0] err;
    logic [11:0] syms;
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sym = '0;
    out_ready = 1'b1;
    nt_in_valid = 1'b0;
    nt_in_sym = '0;
    nt_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_last", out_last, 0);
    check("rst_metric", out_metric, 0);
    check("rst_done", frame_done, 0);
    rst = 1'b0;

    run_frame(4'b1101, 12'h000, 1'b0, 1'b0, 1'b0);
    run_frame(4'b1101, 12'h001, 1'b0, 1'b0, 1'b0);
    run_frame(4'b1101, 12'h000, 1'b1, 1'b1, 1'b1);

    send(encode(4'b1101), 3, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    repeat (10) begin
      @(posedge clk); #1;
      check("abort_quiet", out_valid, 0);
    end
    run_frame(4'b1101, 12'h000, 1'b0, 1'b0, 1'b0);

    run_frame(4'b1101, 12'h000, 1'b0, 1'b0, 1'b0);
    run_frame(4'b0110, 12'h000, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      info = 4'($urandom);
      err = '0;
      if (k < 10) begin
        repeat ($urandom_range(0, 2)) err[$urandom_range(0, 11)] ^= 1'b1;
      end else begin
        err = 12'($urandom);
      end
      run_frame(info, err, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    syms = encode(4'b1101);
    for (int i = 0; i < 4; i++) begin
      nt_in_valid = 1'b1;
      nt_in_sym = syms[2*i +: 2];
      @(posedge clk); #1;
    end
    nt_in_valid = 1'b0;
    n = 0;
    while (!nt_out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("nt_latency", n, 5);
    for (int i = 0; i < 4; i++) begin
      check("nt_bit", nt_out_bit, syms[0] ? (i != 1) : 1'b0);
      check("nt_last", nt_out_last, i == 3);
      check("nt_metric", nt_out_metric, 0);
      @(posedge clk); #1;
    end
    check("nt_done", nt_frame_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
